// File: rtl/gmii_rx_mac.sv
// gmii_rx_mac
//   Receive MAC framer running in the RGMII receive clock domain. It takes the
//   deserialised byte stream, strips preamble/SFD and the 4-byte FCS, checks the
//   CRC-32 residue and the frame length, and forwards payload bytes as single-cycle
//   stream beats. A bad frame is flagged with tuser on its tlast beat.
//
//   Optional feature: define GMII_RX_MAC_STATS_EN to add the frame counters
//   stat_good_frames / stat_bad_frames.
//
// Ports
//   rx_clk         receive clock (rgmii_rxc)
//   rst            synchronous active-high reset
//   gmii_rxd       received byte
//   gmii_dv        receive data valid
//   gmii_er        receive error
//   m_axis_tdata   payload byte
//   m_axis_tvalid  beat valid, single-cycle pulses, no backpressure
//   m_axis_tlast   last payload byte of a frame
//   m_axis_tuser   bad frame, meaningful only with tlast (0 otherwise)
//   stat_good_frames / stat_bad_frames (GMII_RX_MAC_STATS_EN only)

module gmii_rx_mac #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_dv,
    input  logic        gmii_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser
`ifdef GMII_RX_MAC_STATS_EN
   ,output logic [31:0] stat_good_frames,
    output logic [31:0] stat_bad_frames
`endif
);

    localparam logic [10:0] MIN_LEN    = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN    = 11'(MAX_FRAME_LEN);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t          state;
    logic [7:0]      rxd_q;
    logic            dv_q;
    logic            er_q;
    logic [4:0][7:0] line;      // [0] newest ... [4] oldest (the hold byte)
    logic [31:0]     crc;
    logic [10:0]     count;
    logic            er_flag;
    logic            short_eof;

    // One byte of reflected CRC-32 (poly 0xEDB88320), LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // The FSM works on registered GMII inputs. The last four bytes of the frame
    // are the FCS, so every byte is held in a 5-deep line and only leaves once
    // four newer bytes prove it is not FCS. At end of frame the oldest entry is
    // the last payload byte and goes out with tlast.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rxd_q         <= '0;
            dv_q          <= 1'b0;
            er_q          <= 1'b0;
            state         <= ST_IDLE;
            line          <= '0;
            crc           <= 32'hFFFFFFFF;
            count         <= '0;
            er_flag       <= 1'b0;
            short_eof     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            rxd_q         <= gmii_rxd;
            dv_q          <= gmii_dv;
            er_q          <= gmii_er;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            short_eof     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (dv_q) begin
                        state <= (rxd_q == 8'h55) ? ST_PREAMBLE : ST_DROP;
                    end
                end

                ST_PREAMBLE: begin
                    if (!dv_q) begin
                        state <= ST_IDLE;
                    end else if (rxd_q == 8'hD5) begin
                        state   <= ST_PAYLOAD;
                        crc     <= 32'hFFFFFFFF;
                        count   <= '0;
                        er_flag <= 1'b0;
                    end else if (rxd_q != 8'h55) begin
                        state <= ST_DROP;
                    end
                end

                ST_PAYLOAD: begin
                    if (dv_q) begin
                        if (count >= MAX_LEN) begin
                            // Giant: close the frame as bad with the held byte
                            // and discard the remainder.
                            m_axis_tdata  <= line[4];
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tuser  <= 1'b1;
                            state         <= ST_DROP;
                        end else begin
                            line <= {line[3:0], rxd_q};
                            crc  <= crc32_byte(crc, rxd_q);
                            if (count != 11'h7FF) begin
                                count <= count + 11'd1;
                            end
                            if (er_q) begin
                                er_flag <= 1'b1;
                            end
                            if (count >= 11'd5) begin
                                m_axis_tdata  <= line[4];
                                m_axis_tvalid <= 1'b1;
                            end
                        end
                    end else begin
                        if (count >= 11'd5) begin
                            m_axis_tdata  <= line[4];
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tuser  <= er_flag | (crc != CRC_RESIDUE) | (count < MIN_LEN);
                        end else begin
                            short_eof <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (!dv_q) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GMII_RX_MAC_STATS_EN
    // Counters follow the registered output beat, so they move one cycle after
    // the tlast beat is visible. Frames too short to emit anything count as bad.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            stat_good_frames <= '0;
            stat_bad_frames  <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tlast && !m_axis_tuser) begin
                stat_good_frames <= stat_good_frames + 32'd1;
            end
            stat_bad_frames <= stat_bad_frames
                             + {31'd0, m_axis_tvalid & m_axis_tlast & m_axis_tuser}
                             + {31'd0, short_eof};
        end
    end
`else
    logic unused_short_eof;
    assign unused_short_eof = short_eof;
`endif

endmodule

// File: tb/tb_gmii_rx_mac.sv
// tb_gmii_rx_mac
//   Directed bench for gmii_rx_mac: drives whole GMII frames, collects every
//   output beat and compares the beat stream with hand-derived expectations.
//   Build with GMII_RX_MAC_STATS_EN defined to also cover the frame counters.

module tb_gmii_rx_mac;

    logic        rx_clk = 1'b0;
    logic        rst;
    logic [7:0]  gmii_rxd;
    logic        gmii_dv;
    logic        gmii_er;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
`ifdef GMII_RX_MAC_STATS_EN
    logic [31:0] stat_good_frames;
    logic [31:0] stat_bad_frames;
`endif

    int checks = 0;
    int passes = 0;
    int exp_good = 0;
    int exp_bad = 0;

    logic [9:0] beats[$];   // {tuser, tlast, tdata}
    logic [7:0] frame[$];   // bytes after the SFD, FCS included

    gmii_rx_mac dut (
        .rx_clk        (rx_clk),
        .rst           (rst),
        .gmii_rxd      (gmii_rxd),
        .gmii_dv       (gmii_dv),
        .gmii_er       (gmii_er),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef GMII_RX_MAC_STATS_EN
       ,.stat_good_frames (stat_good_frames),
        .stat_bad_frames  (stat_bad_frames)
`endif
    );

    always #5 rx_clk = ~rx_clk;

    always @(negedge rx_clk) begin
        if (m_axis_tvalid === 1'b1) begin
            beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
    end

    // Bit-serial IEEE 802.3 CRC, used only to generate the FCS of test frames.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ d[j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Payload byte i carries the value i[7:0]; four FCS bytes follow, LSB first.
    task automatic build_frame(input int n);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        frame.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = i[7:0];
            frame.push_back(b);
            c = crc_step(c, b);
        end
        fcs = ~c;
        frame.push_back(fcs[7:0]);
        frame.push_back(fcs[15:8]);
        frame.push_back(fcs[23:16]);
        frame.push_back(fcs[31:24]);
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(negedge rx_clk);
        gmii_rxd = d;
        gmii_dv  = dv;
        gmii_er  = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic preamble();
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int er_idx);
        beats.delete();
        preamble();
        foreach (frame[i]) drive(frame[i], 1'b1, (i == er_idx));
        idle(10);
    endtask

    function automatic int first_bad_data();
        foreach (beats[i]) begin
            if (beats[i][7:0] !== i[7:0]) return i;
        end
        return -1;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (beats[i]) if (beats[i][8]) n++;
        return n;
    endfunction

    function automatic logic last_user();
        return (beats.size() > 0) ? beats[beats.size()-1][9] : 1'bx;
    endfunction

    function automatic logic last_tlast();
        return (beats.size() > 0) ? beats[beats.size()-1][8] : 1'bx;
    endfunction

    function automatic int count_user_nonlast();
        int n = 0;
        foreach (beats[i]) if (beats[i][9] && !beats[i][8]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %0d, expected 0", m_axis_tvalid); else passes++;
        checks++; if (m_axis_tlast !== 1'b0) $display("[TB] FAIL reset_tlast: got %0d, expected 0", m_axis_tlast); else passes++;
        checks++; if (m_axis_tuser !== 1'b0) $display("[TB] FAIL reset_tuser: got %0d, expected 0", m_axis_tuser); else passes++;
        checks++; if (m_axis_tdata !== 8'h00) $display("[TB] FAIL reset_tdata: got %0h, expected 0", m_axis_tdata); else passes++;
`ifdef GMII_RX_MAC_STATS_EN
        checks++; if (stat_good_frames !== 32'd0) $display("[TB] FAIL reset_stat_good: got %0d, expected 0", stat_good_frames); else passes++;
        checks++; if (stat_bad_frames !== 32'd0) $display("[TB] FAIL reset_stat_bad: got %0d, expected 0", stat_bad_frames); else passes++;
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        build_frame(60);
        send_frame(-1);
        exp_good++;
        checks++; if (beats.size() !== 60) $display("[TB] FAIL good_beats: got %0d, expected 60", beats.size()); else passes++;
        checks++; if (first_bad_data() !== -1) $display("[TB] FAIL good_data_order: bad at beat %0d, expected none", first_bad_data()); else passes++;
        checks++; if (count_last() !== 1) $display("[TB] FAIL good_tlast_count: got %0d, expected 1", count_last()); else passes++;
        checks++; if (last_tlast() !== 1'b1) $display("[TB] FAIL good_tlast_on_last: got %0d, expected 1", last_tlast()); else passes++;
        checks++; if (last_user() !== 1'b0) $display("[TB] FAIL good_tuser: got %0d, expected 0", last_user()); else passes++;
        checks++; if (count_user_nonlast() !== 0) $display("[TB] FAIL good_tuser_midframe: got %0d, expected 0", count_user_nonlast()); else passes++;
    endtask

    task automatic test_bad_fcs();
        build_frame(60);
        frame[63] = frame[63] ^ 8'h01;
        send_frame(-1);
        exp_bad++;
        checks++; if (beats.size() !== 60) $display("[TB] FAIL fcs_beats: got %0d, expected 60", beats.size()); else passes++;
        checks++; if (last_tlast() !== 1'b1) $display("[TB] FAIL fcs_tlast: got %0d, expected 1", last_tlast()); else passes++;
        checks++; if (last_user() !== 1'b1) $display("[TB] FAIL fcs_tuser: got %0d, expected 1", last_user()); else passes++;
    endtask

    task automatic test_gmii_er();
        build_frame(60);
        send_frame(10);
        exp_bad++;
        checks++; if (beats.size() !== 60) $display("[TB] FAIL er_beats: got %0d, expected 60", beats.size()); else passes++;
        checks++; if (first_bad_data() !== -1) $display("[TB] FAIL er_data_order: bad at beat %0d, expected none", first_bad_data()); else passes++;
        checks++; if (last_user() !== 1'b1) $display("[TB] FAIL er_tuser: got %0d, expected 1", last_user()); else passes++;
    endtask

    task automatic test_preamble_abort();
        beats.delete();
        repeat (5) drive(8'h55, 1'b1, 1'b0);
        idle(8);
        checks++; if (beats.size() !== 0) $display("[TB] FAIL abort_beats: got %0d, expected 0", beats.size()); else passes++;
        build_frame(60);
        send_frame(-1);
        exp_good++;
        checks++; if (beats.size() !== 60) $display("[TB] FAIL abort_next_beats: got %0d, expected 60", beats.size()); else passes++;
        checks++; if (last_user() !== 1'b0) $display("[TB] FAIL abort_next_tuser: got %0d, expected 0", last_user()); else passes++;
    endtask

    task automatic test_short_frame();
        beats.delete();
        preamble();
        for (int i = 0; i < 3; i++) drive(8'hA0 + 8'(i), 1'b1, 1'b0);
        idle(8);
        exp_bad++;
        checks++; if (beats.size() !== 0) $display("[TB] FAIL short_beats: got %0d, expected 0", beats.size()); else passes++;
    endtask

    task automatic test_runt();
        build_frame(20);
        send_frame(-1);
        exp_bad++;
        checks++; if (beats.size() !== 20) $display("[TB] FAIL runt_beats: got %0d, expected 20", beats.size()); else passes++;
        checks++; if (first_bad_data() !== -1) $display("[TB] FAIL runt_data_order: bad at beat %0d, expected none", first_bad_data()); else passes++;
        checks++; if (last_tlast() !== 1'b1) $display("[TB] FAIL runt_tlast: got %0d, expected 1", last_tlast()); else passes++;
        checks++; if (last_user() !== 1'b1) $display("[TB] FAIL runt_tuser: got %0d, expected 1", last_user()); else passes++;
`ifdef GMII_RX_MAC_STATS_EN
        checks++; if (stat_good_frames !== 32'(exp_good)) $display("[TB] FAIL runt_stat_good: got %0d, expected %0d", stat_good_frames, exp_good); else passes++;
        checks++; if (stat_bad_frames !== 32'(exp_bad)) $display("[TB] FAIL runt_stat_bad: got %0d, expected %0d", stat_bad_frames, exp_bad); else passes++;
`endif
    endtask

    task automatic test_reset_mid_frame();
        build_frame(60);
        beats.delete();
        preamble();
        foreach (frame[i]) begin
            drive(frame[i], 1'b1, 1'b0);
            rst = (i == 30);
            if (i == 31) begin
                checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL rst_mid_tvalid: got %0d, expected 0", m_axis_tvalid); else passes++;
            end
        end
        idle(10);
        exp_good = 0;
        exp_bad  = 0;
        checks++; if (count_last() !== 0) $display("[TB] FAIL rst_mid_tlast: got %0d, expected 0", count_last()); else passes++;
        checks++; if (beats.size() >= 30) $display("[TB] FAIL rst_mid_beats: got %0d, expected below 30", beats.size()); else passes++;
        build_frame(60);
        send_frame(-1);
        exp_good++;
        checks++; if (beats.size() !== 60) $display("[TB] FAIL rst_next_beats: got %0d, expected 60", beats.size()); else passes++;
        checks++; if (last_user() !== 1'b0) $display("[TB] FAIL rst_next_tuser: got %0d, expected 0", last_user()); else passes++;
`ifdef GMII_RX_MAC_STATS_EN
        checks++; if (stat_good_frames !== 32'd1) $display("[TB] FAIL rst_stat_good: got %0d, expected 1", stat_good_frames); else passes++;
        checks++; if (stat_bad_frames !== 32'd0) $display("[TB] FAIL rst_stat_bad: got %0d, expected 0", stat_bad_frames); else passes++;
`endif
    endtask

    // 1600 bytes after the SFD. Pushes of bytes 6..1518 shift out bytes 1..1513
    // (1513 plain beats); byte 1519 trips the length limit and the held byte
    // 1514 closes the frame with tlast and tuser set.
    task automatic test_giant();
        build_frame(1596);
        send_frame(-1);
        exp_bad++;
        checks++; if (beats.size() !== 1514) $display("[TB] FAIL giant_beats: got %0d, expected 1514", beats.size()); else passes++;
        checks++; if (first_bad_data() !== -1) $display("[TB] FAIL giant_data_order: bad at beat %0d, expected none", first_bad_data()); else passes++;
        checks++; if (count_last() !== 1) $display("[TB] FAIL giant_tlast_count: got %0d, expected 1", count_last()); else passes++;
        checks++; if (last_tlast() !== 1'b1) $display("[TB] FAIL giant_tlast_on_last: got %0d, expected 1", last_tlast()); else passes++;
        checks++; if (last_user() !== 1'b1) $display("[TB] FAIL giant_tuser: got %0d, expected 1", last_user()); else passes++;
`ifdef GMII_RX_MAC_STATS_EN
        checks++; if (stat_bad_frames !== 32'(exp_bad)) $display("[TB] FAIL giant_stat_bad: got %0d, expected %0d", stat_bad_frames, exp_bad); else passes++;
`endif
    endtask

    initial begin
        rst      = 1'b1;
        gmii_rxd = 8'h00;
        gmii_dv  = 1'b0;
        gmii_er  = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_gmii_er();
        test_preamble_abort();
        test_short_frame();
        test_runt();
        test_reset_mid_frame();
        test_giant();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
